// File: rtl/ddr4_req_queue.sv
// In-order request queue in front of a DDR4 controller. A tag FIFO pairs the
// controller's in-order read data with the requester tag of each issued read.
module ddr4_req_queue #(
    parameter int PADDR_BITS = 19,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int TAG_BITS   = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    req_valid_in,
    output logic                    req_ready_out,
    input  logic                    req_we_in,
    input  logic [PADDR_BITS-1:0]   req_addr_in,
    input  logic [DATA_WIDTH-1:0]   req_wdata_in,
    input  logic [TAG_BITS-1:0]     req_tag_in,
    output logic                    mem_bus_valid_out,
    input  logic                    mem_bus_ready_in,
    output logic                    mem_bus_we_out,
    output logic [PADDR_BITS-1:0]   mem_bus_addr_out,
    output logic [DATA_WIDTH-1:0]   mem_bus_wdata_out,
    input  logic                    mem_rdata_valid_in,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_in,
    output logic                    resp_valid_out,
    output logic [TAG_BITS-1:0]     resp_tag_out,
    output logic [DATA_WIDTH-1:0]   resp_data_out,
    output logic [$clog2(DEPTH):0]  count_out,
    output logic                    err_out
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + PADDR_BITS + DATA_WIDTH + TAG_BITS;

    logic [ENT_W-1:0]      req_mem_q [DEPTH];
    logic [PTR_W-1:0]      req_wr_q, req_wr_d, req_rd_q, req_rd_d;
    logic [CNT_W-1:0]      req_cnt_q, req_cnt_d;
    logic [TAG_BITS-1:0]   tag_mem_q [DEPTH];
    logic [PTR_W-1:0]      tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CNT_W-1:0]      tag_cnt_q, tag_cnt_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [TAG_BITS-1:0]   resp_tag_q, resp_tag_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  err_q, err_d;

    logic                  head_we_s;
    logic [PADDR_BITS-1:0] head_addr_s;
    logic [DATA_WIDTH-1:0] head_wdata_s;
    logic [TAG_BITS-1:0]   head_tag_s;
    logic [TAG_BITS-1:0]   pop_tag_s;
    logic                  req_empty_s, tag_empty_s, tag_full_s;
    logic                  req_push_s, req_pop_s, tag_push_s, tag_pop_s;

    assign {head_we_s, head_addr_s, head_wdata_s, head_tag_s} = req_mem_q[req_rd_q];

    assign req_empty_s = (req_cnt_q == {CNT_W{1'b0}});
    assign tag_empty_s = (tag_cnt_q == {CNT_W{1'b0}});
    assign tag_full_s  = (tag_cnt_q == CNT_W'(DEPTH));

    assign req_ready_out     = (req_cnt_q != CNT_W'(DEPTH));
    assign mem_bus_valid_out = !req_empty_s && (head_we_s || !tag_full_s);
    assign mem_bus_we_out    = req_empty_s ? 1'b0 : head_we_s;
    assign mem_bus_addr_out  = req_empty_s ? {PADDR_BITS{1'b0}} : head_addr_s;
    assign mem_bus_wdata_out = req_empty_s ? {DATA_WIDTH{1'b0}} : head_wdata_s;

    assign req_push_s = req_valid_in && req_ready_out;
    assign req_pop_s  = mem_bus_valid_out && mem_bus_ready_in;
    assign tag_push_s = req_pop_s && !head_we_s;
    // A strobe arriving with the tag FIFO empty is served by a read issuing in the same cycle.
    assign tag_pop_s  = mem_rdata_valid_in && (!tag_empty_s || tag_push_s);
    assign pop_tag_s  = tag_empty_s ? head_tag_s : tag_mem_q[tag_rd_q];

    assign count_out      = req_cnt_q;
    assign resp_valid_out = resp_valid_q;
    assign resp_tag_out   = resp_tag_q;
    assign resp_data_out  = resp_data_q;
    assign err_out        = err_q;

    // Next-state for pointers, occupancies, response register and error flag.
    always_comb begin
        req_wr_d     = req_wr_q;
        req_rd_d     = req_rd_q;
        tag_wr_d     = tag_wr_q;
        tag_rd_d     = tag_rd_q;
        resp_valid_d = 1'b0;
        resp_tag_d   = resp_tag_q;
        resp_data_d  = resp_data_q;
        if (req_push_s) begin
            req_wr_d = req_wr_q + PTR_W'(1'b1);
        end else begin
            req_wr_d = req_wr_q;
        end
        if (req_pop_s) begin
            req_rd_d = req_rd_q + PTR_W'(1'b1);
        end else begin
            req_rd_d = req_rd_q;
        end
        if (tag_push_s) begin
            tag_wr_d = tag_wr_q + PTR_W'(1'b1);
        end else begin
            tag_wr_d = tag_wr_q;
        end
        if (tag_pop_s) begin
            tag_rd_d     = tag_rd_q + PTR_W'(1'b1);
            resp_valid_d = 1'b1;
            resp_tag_d   = pop_tag_s;
            resp_data_d  = mem_rdata_in;
        end else begin
            tag_rd_d     = tag_rd_q;
            resp_valid_d = 1'b0;
        end
        req_cnt_d = req_cnt_q + CNT_W'(req_push_s) - CNT_W'(req_pop_s);
        tag_cnt_d = tag_cnt_q + CNT_W'(tag_push_s) - CNT_W'(tag_pop_s);
        err_d     = err_q || (mem_rdata_valid_in && !tag_pop_s);
    end

    // State registers and FIFO storage.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                req_mem_q[i] <= {ENT_W{1'b0}};
                tag_mem_q[i] <= {TAG_BITS{1'b0}};
            end
            req_wr_q     <= {PTR_W{1'b0}};
            req_rd_q     <= {PTR_W{1'b0}};
            req_cnt_q    <= {CNT_W{1'b0}};
            tag_wr_q     <= {PTR_W{1'b0}};
            tag_rd_q     <= {PTR_W{1'b0}};
            tag_cnt_q    <= {CNT_W{1'b0}};
            resp_valid_q <= 1'b0;
            resp_tag_q   <= {TAG_BITS{1'b0}};
            resp_data_q  <= {DATA_WIDTH{1'b0}};
            err_q        <= 1'b0;
        end else begin
            if (req_push_s) begin
                req_mem_q[req_wr_q] <= {req_we_in, req_addr_in, req_wdata_in, req_tag_in};
            end
            if (tag_push_s) begin
                tag_mem_q[tag_wr_q] <= head_tag_s;
            end
            req_wr_q     <= req_wr_d;
            req_rd_q     <= req_rd_d;
            req_cnt_q    <= req_cnt_d;
            tag_wr_q     <= tag_wr_d;
            tag_rd_q     <= tag_rd_d;
            tag_cnt_q    <= tag_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_tag_q   <= resp_tag_d;
            resp_data_q  <= resp_data_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_ddr4_req_queue.sv
// Bench for ddr4_req_queue: directed scenarios plus random traffic, checked by a
// negedge monitor against a queue-based reference model and response scoreboard.
module tb_ddr4_req_queue;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        req_valid_in, req_ready_out, req_we_in;
    logic [18:0] req_addr_in;
    logic [63:0] req_wdata_in;
    logic [1:0]  req_tag_in;
    logic        mem_bus_valid_out, mem_bus_ready_in, mem_bus_we_out;
    logic [18:0] mem_bus_addr_out;
    logic [63:0] mem_bus_wdata_out;
    logic        mem_rdata_valid_in;
    logic [63:0] mem_rdata_in;
    logic        resp_valid_out;
    logic [1:0]  resp_tag_out;
    logic [63:0] resp_data_out;
    logic [2:0]  count_out;
    logic        err_out;

    ddr4_req_queue dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_we_in(req_we_in), .req_addr_in(req_addr_in),
        .req_wdata_in(req_wdata_in), .req_tag_in(req_tag_in),
        .mem_bus_valid_out(mem_bus_valid_out), .mem_bus_ready_in(mem_bus_ready_in),
        .mem_bus_we_out(mem_bus_we_out), .mem_bus_addr_out(mem_bus_addr_out),
        .mem_bus_wdata_out(mem_bus_wdata_out),
        .mem_rdata_valid_in(mem_rdata_valid_in), .mem_rdata_in(mem_rdata_in),
        .resp_valid_out(resp_valid_out), .resp_tag_out(resp_tag_out),
        .resp_data_out(resp_data_out), .count_out(count_out), .err_out(err_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { logic we; logic [18:0] addr; logic [63:0] wdata; logic [1:0] tag; } req_t;
    typedef struct { logic [1:0] tag; logic [63:0] data; } rsp_t;

    req_t       req_q[$];   // accepted, not yet issued, in acceptance order
    logic [1:0] out_q[$];   // tags of issued reads awaiting data
    rsp_t       rsp_q[$];   // responses expected on the next cycle
    logic       err_exp;
    int         checks = 0;
    int         passes = 0;
    int         resp_cnt = 0;
    int         r0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic we, input logic [18:0] a, input logic [63:0] d, input logic [1:0] t);
        req_valid_in = 1'b1;
        req_we_in    = we;
        req_addr_in  = a;
        req_wdata_in = d;
        req_tag_in   = t;
        cyc();
        req_valid_in = 1'b0;
    endtask

    // Monitor: compare DUT state with the model, then advance the model for the coming edge.
    req_t h;
    rsp_t r, nr;
    logic exp_v, exp_rdy;
    always @(negedge clk_in) begin
        if (rst_in) begin
            req_q.delete();
            out_q.delete();
            rsp_q.delete();
            err_exp = 1'b0;
        end else begin
            chk("resp_valid", resp_valid_out, rsp_q.size() != 0);
            if (resp_valid_out) resp_cnt++;
            if (rsp_q.size() != 0) begin
                r = rsp_q.pop_front();
                if (resp_valid_out) begin
                    chk("resp_tag", resp_tag_out, r.tag);
                    chk("resp_data", resp_data_out, r.data);
                end
            end
            exp_rdy = (req_q.size() != 4);
            exp_v   = (req_q.size() != 0) && (req_q[0].we || out_q.size() < 4);
            chk("count", count_out, req_q.size());
            chk("req_ready", req_ready_out, exp_rdy);
            chk("bus_valid", mem_bus_valid_out, exp_v);
            chk("err", err_out, err_exp);
            if (exp_v && mem_bus_valid_out) begin
                chk("bus_we", mem_bus_we_out, req_q[0].we);
                chk("bus_addr", mem_bus_addr_out, req_q[0].addr);
                chk("bus_wdata", mem_bus_wdata_out, req_q[0].wdata);
            end
            if (exp_v && mem_bus_ready_in) begin
                h = req_q.pop_front();
                if (!h.we) out_q.push_back(h.tag);
            end
            if (mem_rdata_valid_in) begin
                if (out_q.size() != 0) begin
                    nr.tag  = out_q.pop_front();
                    nr.data = mem_rdata_in;
                    rsp_q.push_back(nr);
                end else begin
                    err_exp = 1'b1;
                end
            end
            if (req_valid_in && exp_rdy) begin
                h.we = req_we_in; h.addr = req_addr_in; h.wdata = req_wdata_in; h.tag = req_tag_in;
                req_q.push_back(h);
            end
        end
    end

    initial begin
        rst_in = 1'b1;
        req_valid_in = 1'b0; req_we_in = 1'b0; req_addr_in = 19'h0;
        req_wdata_in = 64'h0; req_tag_in = 2'd0;
        mem_bus_ready_in = 1'b0; mem_rdata_valid_in = 1'b0; mem_rdata_in = 64'h0;
        #1;
        chk("rst_count", count_out, 3'd0);
        chk("rst_ready", req_ready_out, 1'b1);
        chk("rst_bus_valid", mem_bus_valid_out, 1'b0);
        chk("rst_bus_addr", mem_bus_addr_out, 19'h0);
        chk("rst_resp_valid", resp_valid_out, 1'b0);
        chk("rst_err", err_out, 1'b0);
        repeat (2) cyc();
        rst_in = 1'b0;
        cyc();

        // Single read round trip
        mem_bus_ready_in = 1'b1;
        push(1'b0, 19'h1A2B3, 64'h0, 2'd2);
        chk("rd_issue_lat", mem_bus_valid_out, 1'b1);
        chk("rd_issue_addr", mem_bus_addr_out, 19'h1A2B3);
        cyc();
        mem_rdata_valid_in = 1'b1; mem_rdata_in = 64'hDEADBEEF;
        cyc();
        mem_rdata_valid_in = 1'b0;
        chk("rd_resp_valid", resp_valid_out, 1'b1);
        chk("rd_resp_tag", resp_tag_out, 2'd2);
        chk("rd_resp_data", resp_data_out, 64'hDEADBEEF);
        cyc();

        // Fill to full with the controller stalled; full+pop admits no push
        mem_bus_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) push(1'b1, 19'(i + 16), 64'(i * 3), 2'd0);
        chk("full_count", count_out, 3'd4);
        chk("full_ready", req_ready_out, 1'b0);
        req_valid_in = 1'b1; req_we_in = 1'b1; req_addr_in = 19'h7; req_wdata_in = 64'h77;
        mem_bus_ready_in = 1'b1;
        cyc();
        mem_bus_ready_in = 1'b0;
        chk("pop_full_count", count_out, 3'd3);
        chk("pop_full_ready", req_ready_out, 1'b1);
        cyc();
        req_valid_in = 1'b0;
        chk("refill_count", count_out, 3'd4);
        mem_bus_ready_in = 1'b1;
        repeat (6) cyc();

        // Tag FIFO full blocks the fifth read until a strobe frees a slot
        for (int i = 0; i < 5; i++) push(1'b0, 19'(i + 256), 64'h0, 2'(i));
        repeat (3) cyc();
        chk("tagfull_stall", mem_bus_valid_out, 1'b0);
        chk("tagfull_count", count_out, 3'd1);
        mem_rdata_valid_in = 1'b1; mem_rdata_in = {$urandom(), $urandom()};
        cyc();
        chk("tagfull_resp", resp_valid_out, 1'b1);
        chk("tagfull_resp_tag", resp_tag_out, 2'd0);
        chk("tagfull_unblock", mem_bus_valid_out, 1'b1);
        for (int i = 0; i < 4; i++) begin
            mem_rdata_in = {$urandom(), $urandom()};
            cyc();
        end
        mem_rdata_valid_in = 1'b0;
        repeat (2) cyc();

        // Write then read to the same address: in order, one response
        r0 = resp_cnt;
        push(1'b1, 19'h00100, 64'h55, 2'd0);
        push(1'b0, 19'h00100, 64'h0, 2'd1);
        repeat (2) cyc();
        mem_rdata_valid_in = 1'b1; mem_rdata_in = 64'h1234;
        cyc();
        mem_rdata_valid_in = 1'b0;
        repeat (2) cyc();
        chk("wr_rd_one_resp", resp_cnt - r0, 1);

        // Stray strobe: sticky error, no response
        mem_rdata_valid_in = 1'b1;
        cyc();
        mem_rdata_valid_in = 1'b0;
        chk("stray_err", err_out, 1'b1);
        chk("stray_no_resp", resp_valid_out, 1'b0);
        repeat (3) cyc();
        chk("stray_err_held", err_out, 1'b1);

        // Asynchronous reset with queued and outstanding work
        rst_in = 1'b1;
        cyc();
        rst_in = 1'b0;
        mem_bus_ready_in = 1'b1;
        push(1'b0, 19'h11, 64'h0, 2'd1);
        push(1'b0, 19'h22, 64'h0, 2'd3);
        mem_bus_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) push(1'b1, 19'(i + 48), 64'(i + 9), 2'd0);
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_count", count_out, 3'd0);
        chk("arst_ready", req_ready_out, 1'b1);
        chk("arst_bus_valid", mem_bus_valid_out, 1'b0);
        chk("arst_bus_wdata", mem_bus_wdata_out, 64'h0);
        chk("arst_err", err_out, 1'b0);
        chk("arst_resp_tag", resp_tag_out, 2'd0);
        cyc();
        rst_in = 1'b0;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            req_valid_in       = ($urandom_range(0, 1) == 1);
            req_we_in          = ($urandom_range(0, 1) == 1);
            req_addr_in        = 19'($urandom());
            req_wdata_in       = {$urandom(), $urandom()};
            req_tag_in         = 2'($urandom_range(0, 3));
            mem_bus_ready_in   = ($urandom_range(0, 3) != 0);
            mem_rdata_valid_in = (out_q.size() != 0) && ($urandom_range(0, 2) != 0);
            mem_rdata_in       = {$urandom(), $urandom()};
            cyc();
        end
        req_valid_in = 1'b0;
        for (int i = 0; i < 200 && (req_q.size() != 0 || out_q.size() != 0); i++) begin
            mem_bus_ready_in   = 1'b1;
            mem_rdata_valid_in = (out_q.size() != 0);
            mem_rdata_in       = {$urandom(), $urandom()};
            cyc();
        end
        mem_rdata_valid_in = 1'b0;
        repeat (2) cyc();
        chk("drain_left", req_q.size() + out_q.size(), 0);
        chk("drain_count", count_out, 3'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
